quantizer_pipe: RTL and testbench



---
 rtl/quantizer_pkg.sv | 18 +
 rtl/quantizer_pipe_if.sv | 29 ++
 rtl/quantizer_lane.sv | 73 +++++++
 rtl/quantizer_pipe.sv | 81 ++++++++
 tb/tb_quantizer_pipe.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/quantizer_pkg.sv
// Shared constants for the multi-lane quantizer: rounding-mode encodings and
// output range helpers.
package quantizer_pkg;

  localparam logic [1:0] RND_FLOOR     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;
  localparam logic [1:0] RND_TO_ZERO   = 2'd3;

  function automatic longint out_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint out_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/quantizer_pipe_if.sv
// Beat-level handshake bus of the quantizer: input beat plus per-beat config
// on one side, quantized beat with overflow flags on the other.
interface quantizer_pipe_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int NUM_CH    = 4,
  parameter int SHIFT_W   = 5
);
  logic                          i_valid;
  logic                          i_ready;
  logic [NUM_CH*IN_WIDTH-1:0]    i_data;
  logic [SHIFT_W-1:0]            cfg_shift;
  logic [1:0]                    cfg_round;
  logic                          cfg_sat_en;
  logic                          o_valid;
  logic                          o_ready;
  logic [NUM_CH*OUT_WIDTH-1:0]   o_data;
  logic [NUM_CH-1:0]             o_overflow;

  modport master (
    output i_valid, i_data, cfg_shift, cfg_round, cfg_sat_en, o_ready,
    input  i_ready, o_valid, o_data, o_overflow
  );

  modport slave (
    input  i_valid, i_data, cfg_shift, cfg_round, cfg_sat_en, o_ready,
    output i_ready, o_valid, o_data, o_overflow
  );
endinterface

// File: rtl/quantizer_lane.sv
// One lane: stage 1 shifts and rounds into a one-bit-wider intermediate,
// stage 2 range-checks and either clamps or wraps to OUT_WIDTH.
module quantizer_lane
  import quantizer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic signed [IN_WIDTH-1:0]  x_i,
  input  logic [SHIFT_W-1:0]          shift_i,
  input  logic [1:0]                  round_i,
  input  logic                        sat_en_i,
  output logic [OUT_WIDTH-1:0]        y_o,
  output logic                        ovf_o
);
  localparam int W1 = IN_WIDTH + 1;
  localparam logic signed [W1-1:0]      MAXV    = W1'(out_max(OUT_WIDTH));
  localparam logic signed [W1-1:0]      MINV    = W1'(out_min(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]      MAX_OUT = OUT_WIDTH'(out_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]      MIN_OUT = OUT_WIDTH'(out_min(OUT_WIDTH));
  localparam logic signed [W1-1:0]      ONE     = W1'(1);

  logic signed [W1-1:0] xe, pow, half, mask, rnd_d, val1_q;
  logic                 sat1_q;
  logic [OUT_WIDTH-1:0] y_d, y_q;
  logic                 ovf_d, ovf_q;

  always_comb begin
    xe   = {x_i[IN_WIDTH-1], x_i};
    pow  = ONE << shift_i;
    half = pow >>> 1;
    mask = pow - ONE;
    rnd_d = xe >>> shift_i;
    case (round_i)
      RND_FLOOR:   rnd_d = xe >>> shift_i;
      RND_HALF_UP: rnd_d = (xe + half) >>> shift_i;
      RND_HALF_EVEN: begin
        rnd_d = (xe + half) >>> shift_i;
        // exact tie that rounded up to an odd value: pull back to even
        if (((xe & mask) == half) && rnd_d[0]) rnd_d = rnd_d - ONE;
      end
      default: rnd_d = xe[W1-1] ? ((xe + mask) >>> shift_i) : (xe >>> shift_i);
    endcase
    if (shift_i == '0) rnd_d = xe;
  end

  always_comb begin
    ovf_d = (val1_q > MAXV) || (val1_q < MINV);
    y_d   = val1_q[OUT_WIDTH-1:0];
    if (ovf_d && sat1_q) y_d = val1_q[W1-1] ? MIN_OUT : MAX_OUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val1_q <= '0;
      sat1_q <= 1'b0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (en_i) begin
      val1_q <= rnd_d;
      sat1_q <= sat_en_i;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end

  assign y_o   = y_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/quantizer_pipe.sv
// Multi-lane two-stage saturating quantizer with valid/ready backpressure
// and saturation statistics.
module quantizer_pipe
  import quantizer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int NUM_CH    = 4,
  parameter int SHIFT_W   = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  quantizer_pipe_if.slave       bus,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  sat_count,
  output logic                  sat_sticky
);
  logic                         advance;
  logic                         v1_q, v2_q;
  logic [NUM_CH*OUT_WIDTH-1:0]  data_w;
  logic [NUM_CH-1:0]            ovf_w;
  logic [CNT_WIDTH-1:0]         cnt_d, cnt_q;
  logic                         sticky_d, sticky_q;

  // Whole pipe moves together; a held output beat freezes both stages.
  assign advance     = !v2_q || bus.o_ready;
  assign bus.i_ready = advance;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    quantizer_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT_W  (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (advance),
      .x_i     (bus.i_data[g*IN_WIDTH +: IN_WIDTH]),
      .shift_i (bus.cfg_shift),
      .round_i (bus.cfg_round),
      .sat_en_i(bus.cfg_sat_en),
      .y_o     (data_w[g*OUT_WIDTH +: OUT_WIDTH]),
      .ovf_o   (ovf_w[g])
    );
  end

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr_stats) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (v2_q && bus.o_ready && (|ovf_w)) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (advance) begin
        v1_q <= bus.i_valid;
        v2_q <= v1_q;
      end
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.o_valid    = v2_q;
  assign bus.o_data     = data_w;
  assign bus.o_overflow = ovf_w;
  assign sat_count      = cnt_q;
  assign sat_sticky     = sticky_q;
endmodule

// File: tb/tb_quantizer_pipe.sv
// Scoreboard bench for quantizer_pipe: directed beats push expectations,
// a monitor pops and compares on every output handshake.
module tb_quantizer_pipe;
  localparam int IW = 32;
  localparam int OW = 16;
  localparam int NC = 4;
  localparam int SW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] sat_count;
  logic          sat_sticky;

  always #5 clk = ~clk;

  quantizer_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_CH(NC), .SHIFT_W(SW)) bus ();

  quantizer_pipe #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_CH(NC), .SHIFT_W(SW), .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_stats (clr_stats),
    .sat_count (sat_count),
    .sat_sticky(sat_sticky)
  );

  typedef struct packed {
    logic [NC*OW-1:0] data;
    logic [NC-1:0]    ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [NC*IW-1:0] d, input logic [SW-1:0] s, input logic [1:0] r,
                      input logic sat, input logic [NC*OW-1:0] ed, input logic [NC-1:0] eo);
    int   guard;
    logic rdy;
    guard = 0;
    bus.i_data     = d;
    bus.cfg_shift  = s;
    bus.cfg_round  = r;
    bus.cfg_sat_en = sat;
    bus.i_valid    = 1'b1;
    forever begin
      #1;
      rdy = bus.i_ready;
      @(posedge clk);
      if (rdy) begin
        sb.push_back(exp_t'{data: ed, ovf: eo});
        break;
      end
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=no_accept required=accept");
        break;
      end
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
    #3;
  endtask

  // Monitor: samples mid-cycle, well after the negedge-driven stimulus settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", bus.o_data);
        end else if (bus.o_ready) begin
          e = sb.pop_front();
          chk("o_data", 64'(bus.o_data), 64'(e.data));
          chk("o_overflow", 64'(bus.o_overflow), 64'(e.ovf));
        end else begin
          chk("stall_o_data", 64'(bus.o_data), 64'(sb[0].data));
          chk("stall_i_ready", 64'(bus.i_ready), 64'(0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_data     = '0;
    bus.cfg_shift  = '0;
    bus.cfg_round  = '0;
    bus.cfg_sat_en = 1'b0;
    bus.o_ready    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_o_data", 64'(bus.o_data), 64'(0));
    chk("rst_o_overflow", 64'(bus.o_overflow), 64'(0));
    chk("rst_sat_count", 64'(sat_count), 64'(0));
    chk("rst_sat_sticky", 64'(sat_sticky), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Clamp at shift 0
    send({32'h00007FFF, 32'hFFFE0000, 32'hFFFF8000, 32'h00012345}, 5'd0, 2'd1, 1'b1,
         {16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF}, 4'b0101);
    // Rounding modes, shift 4, lanes 0x18, 0x28, -0x18, 0
    send({32'h0, 32'hFFFFFFE8, 32'h28, 32'h18}, 5'd4, 2'd0, 1'b1, 64'h0000_FFFE_0002_0001, 4'b0);
    send({32'h0, 32'hFFFFFFE8, 32'h28, 32'h18}, 5'd4, 2'd1, 1'b1, 64'h0000_FFFF_0003_0002, 4'b0);
    send({32'h0, 32'hFFFFFFE8, 32'h28, 32'h18}, 5'd4, 2'd2, 1'b1, 64'h0000_FFFE_0002_0002, 4'b0);
    send({32'h0, 32'hFFFFFFE8, 32'h28, 32'h18}, 5'd4, 2'd3, 1'b1, 64'h0000_FFFF_0002_0001, 4'b0);
    // Wrap
    send({32'h0, 32'h0, 32'h0, 32'h00012345}, 5'd0, 2'd0, 1'b0, 64'h0000_0000_0000_2345, 4'b0001);
    wait_drain();
    chk("stats_count_2", 64'(sat_count), 64'(2));
    chk("stats_sticky_set", 64'(sat_sticky), 64'(1));

    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    #3;
    chk("clr_count", 64'(sat_count), 64'(0));
    chk("clr_sticky", 64'(sat_sticky), 64'(0));
    @(negedge clk);

    // Backpressure: 8 beats with a 3-cycle o_ready drop
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [NC*IW-1:0] d;
          logic [NC*OW-1:0] e;
          for (int l = 0; l < NC; l++) begin
            d[l*IW +: IW] = IW'(k*4 + l + 1);
            e[l*OW +: OW] = OW'(k*4 + l + 1);
          end
          send(d, 5'd0, 2'd0, 1'b1, e, 4'b0);
        end
      end
      begin
        repeat (4) @(negedge clk);
        bus.o_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.o_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count_zero", 64'(sat_count), 64'(0));

    // Counter saturation at 2 bits
    for (int k = 0; k < 5; k++)
      send({32'h0, 32'h0, 32'h0, 32'h00012345}, 5'd0, 2'd0, 1'b0, 64'h0000_0000_0000_2345, 4'b0001);
    wait_drain();
    chk("sat_count_hold", 64'(sat_count), 64'(3));
    chk("sat_sticky_hold", 64'(sat_sticky), 64'(1));

    // Clear coincident with a sixth overflow handshake
    @(negedge clk);
    bus.o_ready = 1'b0;
    send({32'h0, 32'h0, 32'h0, 32'h00012345}, 5'd0, 2'd0, 1'b0, 64'h0000_0000_0000_2345, 4'b0001);
    @(negedge clk);
    bus.o_ready = 1'b1;
    clr_stats   = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    #3;
    chk("clr_wins_count", 64'(sat_count), 64'(0));
    chk("clr_wins_sticky", 64'(sat_sticky), 64'(0));
    wait_drain();

    // Reset with two beats in flight
    @(negedge clk);
    bus.o_ready = 1'b0;
    send({32'h0, 32'h0, 32'h0, 32'h11}, 5'd0, 2'd0, 1'b1, 64'h11, 4'b0);
    send({32'h0, 32'h0, 32'h0, 32'h22}, 5'd0, 2'd0, 1'b1, 64'h22, 4'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    chk("flush_o_valid", 64'(bus.o_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.o_ready = 1'b1;
    send({32'h0, 32'h0, 32'h0, 32'h33}, 5'd0, 2'd0, 1'b1, 64'h33, 4'b0);
    #1;
    chk("post_rst_lat1", 64'(bus.o_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("post_rst_lat2", 64'(bus.o_valid), 64'(1));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
